// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: VGA fetch has fixed priority, the Avalon CPU
// slave is forced through after STARVE_LIMIT lost cycles.
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vga_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic                vga_gnt,
    output logic [DATA_W-1:0]   vga_rdata,
    output logic                vga_rvalid,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [ADDR_W-1:0]   avl_address,
    input  logic [DATA_W-1:0]   avl_writedata,
    input  logic [DATA_W/8-1:0] avl_byteenable,
    output logic [DATA_W-1:0]   avl_readdata,
    output logic                avl_waitrequest,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, CPU_RD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic             cpu_pend, cpu_win, cpu_wr_win;

    always_comb begin
        cpu_pend   = (state == IDLE) & (avl_read | avl_write);
        cpu_win    = cpu_pend & (~vga_req | (wait_cnt >= LIMIT));
        // a simultaneous read+write strobe is resolved as a write
        cpu_wr_win = cpu_win & avl_write;

        state_nxt = IDLE;
        if (cpu_win && !avl_write)
            state_nxt = CPU_RD;

        wait_nxt = '0;
        if (cpu_pend && !cpu_win)
            wait_nxt = (wait_cnt >= LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);

        vga_gnt         = ~reset & vga_req & ~cpu_win;
        mem_addr        = cpu_win ? avl_address : vga_addr;
        mem_we          = ~reset & cpu_wr_win;
        mem_wdata       = avl_writedata;
        mem_be          = avl_byteenable;
        // CPU_RD completes the read regardless of VGA using the port that cycle
        avl_waitrequest = ~reset & (avl_read | avl_write)
                          & ~(cpu_wr_win | (state == CPU_RD));
        avl_readdata    = mem_rdata;
        vga_rdata       = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            vga_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            vga_rvalid <= vga_gnt;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules and the RAM contents.
module tb_vram_arbiter;
    localparam int AW = 11, DW = 32, BW = 4, LIM = 4;

    logic          clk = 1'b0, reset;
    logic          vga_req, vga_gnt, vga_rvalid;
    logic [AW-1:0] vga_addr, avl_address, mem_addr;
    logic [DW-1:0] vga_rdata, avl_writedata, avl_readdata, mem_wdata, mem_rdata;
    logic          avl_read, avl_write, avl_waitrequest, mem_we;
    logic [BW-1:0] avl_byteenable, mem_be;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .avl_read(avl_read), .avl_write(avl_write), .avl_address(avl_address),
        .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
        .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // the shared RAM itself: 1-cycle read latency, byte-lane writes
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < BW; b++)
                if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [DW-1:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    int n_cmp = 0, n_err = 0;

    // reference model: consecutive CPU losses, read-in-flight flag, RAM image
    bit            m_busy, m_rv, m_rv_known;
    int            m_loss;
    logic [DW-1:0] m_rv_data, m_rd_data;
    bit            e_gnt, e_we, e_wait, e_win;

    task automatic model_comb();
        bit pend;
        if (reset) begin
            e_gnt = 0; e_we = 0; e_wait = 0; e_win = 0;
        end else begin
            pend   = !m_busy && (avl_read || avl_write);
            e_win  = pend && (!vga_req || m_loss >= LIM);
            e_gnt  = vga_req && !e_win;
            e_we   = e_win && avl_write;
            e_wait = (avl_read || avl_write) && !e_we && !m_busy;
        end
    endtask

    task automatic drive(input bit rst, input bit vreq, input int vaddr, input bit rd,
                         input bit wr, input int addr, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be);
        reset = rst; vga_req = vreq; vga_addr = AW'(vaddr);
        avl_read = rd; avl_write = wr; avl_address = AW'(addr);
        avl_writedata = wd; avl_byteenable = be;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_loss = 0; m_rv = 0;
        end else begin
            m_rv      = e_gnt;
            m_rv_data = ref_mem[vga_addr];
            if (e_win && !avl_write) m_rd_data = ref_mem[avl_address];
            if (e_we)
                for (int b = 0; b < BW; b++)
                    if (avl_byteenable[b]) ref_mem[avl_address][b*8 +: 8] = avl_writedata[b*8 +: 8];
            if (!m_busy && (avl_read || avl_write) && !e_win) m_loss = (m_loss < LIM) ? m_loss + 1 : LIM;
            else m_loss = 0;
            m_busy = e_win && !avl_write;
        end
        m_rv_known = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 1, 5, 0, 1, 'h30, 32'hA5A5A5A5, 4'hF);
        n_cmp++; if ({vga_gnt, mem_we, avl_waitrequest} !== 3'b000) begin n_err++; $display("FAIL rst1_outs got %b want 000", {vga_gnt, mem_we, avl_waitrequest}); end
        tick();
        drive(1, 1, 5, 0, 1, 'h30, 32'hA5A5A5A5, 4'hF);
        n_cmp++; if ({vga_gnt, mem_we, avl_waitrequest, vga_rvalid} !== 4'b0000) begin n_err++; $display("FAIL rst2_outs got %b want 0000", {vga_gnt, mem_we, avl_waitrequest, vga_rvalid}); end
        tick();
        drive(0, 1, 5, 0, 1, 'h30, 32'hA5A5A5A5, 4'hF);
        n_cmp++; if ({vga_gnt, mem_we, avl_waitrequest} !== 3'b101) begin n_err++; $display("FAIL rst_first_gnt got %b want 101", {vga_gnt, mem_we, avl_waitrequest}); end
        n_cmp++; if (mem_addr !== 11'd5) begin n_err++; $display("FAIL rst_first_addr got %h want 005", mem_addr); end
        tick();
        drive(0, 0, 5, 0, 1, 'h30, 32'hA5A5A5A5, 4'hF);
        n_cmp++; if ({vga_rvalid, mem_we, avl_waitrequest} !== 3'b110) begin n_err++; $display("FAIL rst_after_wr got %b want 110", {vga_rvalid, mem_we, avl_waitrequest}); end
        n_cmp++; if (vga_rdata !== init_word(5)) begin n_err++; $display("FAIL rst_vga_rdata got %h want %h", vga_rdata, init_word(5)); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_write_read();
        drive(0, 0, 0, 0, 1, 'h010, 32'hDEADBEEF, 4'hF);
        n_cmp++; if ({avl_waitrequest, mem_we} !== 2'b01) begin n_err++; $display("FAIL wr_strobes got %b want 01", {avl_waitrequest, mem_we}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== {11'h010, 32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL wr_port got %h %h %h want 010 deadbeef f", mem_addr, mem_wdata, mem_be); end
        tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({avl_waitrequest, mem_we, mem_addr} !== {2'b10, 11'h010}) begin n_err++; $display("FAIL rd_c1 got %b %b %h want 1 0 010", avl_waitrequest, mem_we, mem_addr); end
        tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({avl_waitrequest, avl_readdata} !== {1'b0, 32'hDEADBEEF}) begin n_err++; $display("FAIL rd_c2 got %b %h want 0 deadbeef", avl_waitrequest, avl_readdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (avl_waitrequest !== 1'b0) begin n_err++; $display("FAIL idle_wait got %b want 0", avl_waitrequest); end
        tick();
    endtask

    task automatic test_byte_enable();
        drive(0, 0, 0, 0, 1, 'h010, 32'h11223344, 4'h3);
        n_cmp++; if ({avl_waitrequest, mem_we, mem_be} !== {2'b01, 4'h3}) begin n_err++; $display("FAIL be_wr got %b %b %h want 0 1 3", avl_waitrequest, mem_we, mem_be); end
        tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({avl_waitrequest, avl_readdata} !== {1'b0, 32'hDEAD3344}) begin n_err++; $display("FAIL be_rd got %b %h want 0 dead3344", avl_waitrequest, avl_readdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_starvation();
        int  vaddr = 'h100, prev_addr = 0;
        bit  done = 0, exp_g, exp_rv;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            drive(0, 1, vaddr, 0, !done, 'h040, 32'hCAFEF00D, 4'hF);
            exp_g  = (cyc != 5);
            exp_rv = (cyc >= 2 && cyc != 6);
            n_cmp++; if (vga_gnt !== exp_g) begin n_err++; $display("FAIL starve_gnt c%0d got %b want %b", cyc, vga_gnt, exp_g); end
            n_cmp++; if (vga_rvalid !== exp_rv) begin n_err++; $display("FAIL starve_rvalid c%0d got %b want %b", cyc, vga_rvalid, exp_rv); end
            if (exp_rv) begin
                n_cmp++; if (vga_rdata !== init_word(prev_addr)) begin n_err++; $display("FAIL starve_rdata c%0d got %h want %h", cyc, vga_rdata, init_word(prev_addr)); end
            end
            if (cyc <= 5) begin
                n_cmp++; if ({mem_we, avl_waitrequest} !== ((cyc == 5) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL starve_cpu c%0d got %b", cyc, {mem_we, avl_waitrequest}); end
            end
            if (exp_g) begin prev_addr = vaddr; vaddr++; end
            if (cyc == 5) done = 1;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_pipelined_read();
        drive(0, 1, 'h111, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({vga_gnt, avl_waitrequest} !== 2'b11) begin n_err++; $display("FAIL pipe_c1 got %b want 11", {vga_gnt, avl_waitrequest}); end
        tick();
        drive(0, 0, 'h111, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({vga_gnt, avl_waitrequest, vga_rvalid, mem_addr} !== {3'b011, 11'h010}) begin n_err++; $display("FAIL pipe_c2 got %b %h want 011 010", {vga_gnt, avl_waitrequest, vga_rvalid}, mem_addr); end
        n_cmp++; if (vga_rdata !== init_word('h111)) begin n_err++; $display("FAIL pipe_vga1 got %h want %h", vga_rdata, init_word('h111)); end
        tick();
        drive(0, 1, 'h222, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({vga_gnt, avl_waitrequest, mem_addr} !== {2'b10, 11'h222}) begin n_err++; $display("FAIL pipe_c3 got %b %h want 10 222", {vga_gnt, avl_waitrequest}, mem_addr); end
        n_cmp++; if (avl_readdata !== 32'hDEAD3344) begin n_err++; $display("FAIL pipe_cpu got %h want dead3344", avl_readdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if ({vga_rvalid, vga_rdata} !== {1'b1, init_word('h222)}) begin n_err++; $display("FAIL pipe_vga2 got %b %h want 1 %h", vga_rvalid, vga_rdata, init_word('h222)); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if (avl_waitrequest !== 1'b1) begin n_err++; $display("FAIL rmr_c1 got %b want 1", avl_waitrequest); end
        tick();
        drive(1, 1, 'h123, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({vga_gnt, avl_waitrequest, mem_we} !== 3'b000) begin n_err++; $display("FAIL rmr_rst got %b want 000", {vga_gnt, avl_waitrequest, mem_we}); end
        tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({avl_waitrequest, vga_rvalid} !== 2'b10) begin n_err++; $display("FAIL rmr_reissue got %b want 10", {avl_waitrequest, vga_rvalid}); end
        tick();
        drive(0, 0, 0, 1, 0, 'h010, 0, 0);
        n_cmp++; if ({avl_waitrequest, avl_readdata} !== {1'b0, 32'hDEAD3344}) begin n_err++; $display("FAIL rmr_done got %b %h want 0 dead3344", avl_waitrequest, avl_readdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        bit            cpu_act = 0, cpu_isw = 0, vga_act = 0, rst;
        int            addr = 0, vaddr = 0, age = 0;
        logic [DW-1:0] wd = '0;
        logic [BW-1:0] be = '0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!cpu_act && $urandom_range(0, 2) == 0) begin
                cpu_act = 1; cpu_isw = 1'($urandom_range(0, 1)); age = 0;
                addr = $urandom_range(0, 15); wd = $urandom; be = 4'($urandom_range(0, 15));
            end
            if (!vga_act && $urandom_range(0, 1) == 1) begin vga_act = 1; vaddr = $urandom_range(0, 15); end
            drive(rst, vga_act, vaddr, cpu_act && !cpu_isw, cpu_act && cpu_isw, addr, wd, be);
            n_cmp++; if ({vga_gnt, avl_waitrequest, mem_we} !== {e_gnt, e_wait, e_we}) begin n_err++; $display("FAIL rnd_ctl i%0d got %b want %b", i, {vga_gnt, avl_waitrequest, mem_we}, {e_gnt, e_wait, e_we}); end
            if (e_we) begin
                n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== {AW'(addr), wd, be}) begin n_err++; $display("FAIL rnd_wport i%0d got %h %h %h", i, mem_addr, mem_wdata, mem_be); end
            end
            if (e_gnt) begin
                n_cmp++; if (mem_addr !== AW'(vaddr)) begin n_err++; $display("FAIL rnd_vaddr i%0d got %h want %h", i, mem_addr, vaddr); end
            end
            if (m_rv_known) begin
                n_cmp++; if (vga_rvalid !== m_rv) begin n_err++; $display("FAIL rnd_rvalid i%0d got %b want %b", i, vga_rvalid, m_rv); end
            end
            if (m_rv) begin
                n_cmp++; if (vga_rdata !== m_rv_data) begin n_err++; $display("FAIL rnd_vdata i%0d got %h want %h", i, vga_rdata, m_rv_data); end
            end
            if (m_busy && !rst) begin
                n_cmp++; if (avl_readdata !== m_rd_data) begin n_err++; $display("FAIL rnd_rdata i%0d got %h want %h", i, avl_readdata, m_rd_data); end
            end
            if (cpu_act) age++;
            if (rst) begin
                cpu_act = 0; vga_act = 0;
            end else begin
                if (cpu_act && !e_wait) begin
                    n_cmp++; if (age > (cpu_isw ? LIM + 1 : LIM + 2)) begin n_err++; $display("FAIL rnd_latency i%0d got %0d cycles want <= %0d", i, age, cpu_isw ? LIM + 1 : LIM + 2); end
                    cpu_act = 0;
                end
                if (vga_act && e_gnt) vga_act = 0;
            end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram[a] = init_word(a); ref_mem[a] = init_word(a);
        end
        m_busy = 0; m_rv = 0; m_rv_known = 0; m_loss = 0; m_rv_data = '0; m_rd_data = '0;
        reset = 1; vga_req = 0; vga_addr = '0; avl_read = 0; avl_write = 0;
        avl_address = '0; avl_writedata = '0; avl_byteenable = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_starvation();
        test_pipelined_read();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
